// File: rtl/sync_ptr_w2r_mc.sv
// Multi-channel Gray write-pointer synchroniser into the read domain, with a
// registered decode stage: binary pointer, advance pulse, step size, sticky step error.
module sync_ptr_w2r_mc #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_CH      = 1
) (
    input  logic                             rclk,
    input  logic                             rrst,
    input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0] wptr_gray,
    input  logic [NUM_CH-1:0]                err_clr,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] rq_wptr_gray,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] rq_wptr_bin,
    output logic [NUM_CH-1:0]                wptr_adv,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] wptr_delta,
    output logic [NUM_CH-1:0]                ptr_err
);
    localparam int unsigned   PW    = ADDR_WIDTH + 1;
    localparam int unsigned   BW    = NUM_CH * PW;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_ptr_w2r_mc: SYNC_STAGES must be in 2..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_channels
        $error("sync_ptr_w2r_mc: NUM_CH must be in 1..8");
    end

    // Each stage carries every channel side by side; channels never interact.
    logic [SYNC_STAGES-1:0][BW-1:0] sync_q;

    logic [BW-1:0]     bin_q, bin_d;
    logic [BW-1:0]     delta_q, delta_d;
    logic [NUM_CH-1:0] adv_q, adv_d;
    logic [NUM_CH-1:0] err_q, err_d;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int unsigned i = 1; i < PW; i++) begin
            b[PW-1-i] = b[PW-i] ^ g[PW-1-i];
        end
        return b;
    endfunction

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= wptr_gray;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign rq_wptr_gray = sync_q[SYNC_STAGES-1];

    // bin_q doubles as the previous sample; set wins over a coincident clear.
    always_comb begin
        bin_d   = '0;
        delta_d = '0;
        adv_d   = '0;
        err_d   = err_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            bin_d[c*PW +: PW]   = gray2bin(rq_wptr_gray[c*PW +: PW]);
            delta_d[c*PW +: PW] = bin_d[c*PW +: PW] - bin_q[c*PW +: PW];
            adv_d[c]            = (bin_d[c*PW +: PW] != bin_q[c*PW +: PW]);
            if (delta_d[c*PW +: PW] > DEPTH) begin
                err_d[c] = 1'b1;
            end else if (err_clr[c]) begin
                err_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            bin_q   <= '0;
            delta_q <= '0;
            adv_q   <= '0;
            err_q   <= '0;
        end else begin
            bin_q   <= bin_d;
            delta_q <= delta_d;
            adv_q   <= adv_d;
            err_q   <= err_d;
        end
    end

    assign rq_wptr_bin = bin_q;
    assign wptr_delta  = delta_q;
    assign wptr_adv    = adv_q;
    assign ptr_err     = err_q;

endmodule

// File: tb/tb_sync_ptr_w2r_mc.sv
// Bench for sync_ptr_w2r_mc: a 3-channel/2-stage and a 1-channel/4-stage instance
// checked every cycle against a sample-history reference model.
module tb_sync_ptr_w2r_mc;

    logic        rclk = 1'b0;
    logic        rrst;
    logic [14:0] wa, rqa_g, rqa_b, dla;
    logic [2:0]  clra, adva, erra;
    logic [4:0]  wb, rqb_g, rqb_b, dlb;
    logic        clrb, advb, errb;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Model: history of input samples since reset (newest first) plus sticky errors.
    logic [31:0] hist_a[$];
    logic [31:0] hist_b[$];
    logic [2:0]  me_a;
    logic        me_b;

    sync_ptr_w2r_mc #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .NUM_CH(3)) dut_a (
        .rclk(rclk), .rrst(rrst), .wptr_gray(wa), .err_clr(clra),
        .rq_wptr_gray(rqa_g), .rq_wptr_bin(rqa_b), .wptr_adv(adva),
        .wptr_delta(dla), .ptr_err(erra)
    );

    sync_ptr_w2r_mc #(.ADDR_WIDTH(4), .SYNC_STAGES(4), .NUM_CH(1)) dut_b (
        .rclk(rclk), .rrst(rrst), .wptr_gray(wb), .err_clr(clrb),
        .rq_wptr_gray(rqb_g), .rq_wptr_bin(rqb_b), .wptr_adv(advb),
        .wptr_delta(dlb), .ptr_err(errb)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b = '0;
        for (int s = 0; s < 5; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] chan(input logic [31:0] v, input int c);
        return v[c*5 +: 5];
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int idx);
        return (q.size() > idx) ? q[idx] : 32'd0;
    endfunction

    function automatic logic [4:0] bexp(input logic [31:0] q[$], input int s, input int c);
        return g2b(chan(at(q, s), c));
    endfunction

    function automatic logic [4:0] dexp(input logic [31:0] q[$], input int s, input int c);
        logic [4:0] x;
        x = bexp(q, s, c) - g2b(chan(at(q, s + 1), c));
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist_a.delete();
        hist_b.delete();
        me_a = '0;
        me_b = 1'b0;
    endtask

    task automatic model_edge();
        if (rrst) begin
            model_clear();
        end else begin
            hist_a.push_front({17'd0, wa});
            hist_b.push_front({27'd0, wb});
            if (hist_a.size() > 8) void'(hist_a.pop_back());
            if (hist_b.size() > 8) void'(hist_b.pop_back());
            for (int c = 0; c < 3; c++) begin
                if (dexp(hist_a, 2, c) > 5'd16) me_a[c] = 1'b1;
                else if (clra[c]) me_a[c] = 1'b0;
            end
            if (dexp(hist_b, 4, 0) > 5'd16) me_b = 1'b1;
            else if (clrb) me_b = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [14:0] eg, ebn, ed;
        logic [2:0]  ev;
        for (int c = 0; c < 3; c++) begin
            eg[c*5 +: 5]  = chan(at(hist_a, 1), c);
            ebn[c*5 +: 5] = bexp(hist_a, 2, c);
            ed[c*5 +: 5]  = dexp(hist_a, 2, c);
            ev[c]         = (dexp(hist_a, 2, c) != 5'd0);
        end
        chk({tag, ".a_gray"},  {17'd0, rqa_g}, {17'd0, eg});
        chk({tag, ".a_bin"},   {17'd0, rqa_b}, {17'd0, ebn});
        chk({tag, ".a_delta"}, {17'd0, dla},   {17'd0, ed});
        chk({tag, ".a_adv"},   {29'd0, adva},  {29'd0, ev});
        chk({tag, ".a_err"},   {29'd0, erra},  {29'd0, me_a});
        chk({tag, ".b_gray"},  {27'd0, rqb_g}, {27'd0, chan(at(hist_b, 3), 0)});
        chk({tag, ".b_bin"},   {27'd0, rqb_b}, {27'd0, bexp(hist_b, 4, 0)});
        chk({tag, ".b_delta"}, {27'd0, dlb},   {27'd0, dexp(hist_b, 4, 0)});
        chk({tag, ".b_adv"},   {31'd0, advb},  {31'd0, (dexp(hist_b, 4, 0) != 5'd0)});
        chk({tag, ".b_err"},   {31'd0, errb},  {31'd0, me_b});
    endtask

    task automatic step(input string tag);
        @(posedge rclk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Called just after a check (edge+1): reset lands mid-cycle, well before the next edge.
    task automatic async_rst(input string tag);
        #2;
        rrst = 1'b1;
        #1;
        model_clear();
        check_all(tag);
        chk({tag, ".a_gray0"}, {17'd0, rqa_g}, 32'd0);
        chk({tag, ".a_bin0"},  {17'd0, rqa_b}, 32'd0);
    endtask

    logic [4:0] pa[3];
    logic [4:0] pb;

    initial begin
        model_clear();
        rrst = 1'b1;
        wa   = 15'b10101;
        wb   = 5'b10101;
        clra = '0;
        clrb = 1'b0;

        // Reset held, then release with a nonzero pointer present
        repeat (3) step("rst_hold");
        rrst = 1'b0;
        repeat (3) step("rst_rel");
        chk("rst_rel.a_bin25",   {27'd0, rqa_b[4:0]}, 32'd25);
        chk("rst_rel.a_delta25", {27'd0, dla[4:0]},   32'd25);
        chk("rst_rel.a_err",     {31'd0, erra[0]},    32'd1);
        repeat (2) step("rst_rel_b");
        chk("rst_rel.b_bin25", {27'd0, rqb_b}, 32'd25);
        chk("rst_rel.b_err",   {31'd0, errb},  32'd1);
        repeat (2) step("rst_settle");
        clra = '1;
        clrb = 1'b1;
        step("clr_alone");
        chk("clr_alone.a_err", {29'd0, erra}, 32'd0);
        chk("clr_alone.b_err", {31'd0, errb}, 32'd0);
        clra = '0;
        clrb = 1'b0;

        // Latency 0 -> 1
        rrst = 1'b1;
        wa = '0;
        wb = '0;
        step("lat_rst");
        rrst = 1'b0;
        wa = 15'd1;
        wb = 5'd1;
        step("lat_e1");
        step("lat_e2");
        chk("lat_e2.a_gray", {27'd0, rqa_g[4:0]}, 32'd1);
        step("lat_e3");
        chk("lat_e3.a_bin",   {27'd0, rqa_b[4:0]}, 32'd1);
        chk("lat_e3.a_delta", {27'd0, dla[4:0]},   32'd1);
        chk("lat_e3.a_adv",   {31'd0, adva[0]},    32'd1);
        step("lat_e4");
        chk("lat_e4.a_adv",   {31'd0, adva[0]},    32'd0);
        chk("lat_e4.b_gray",  {27'd0, rqb_g},      32'd1);
        step("lat_e5");
        chk("lat_e5.b_adv",   {31'd0, advb},       32'd1);
        chk("lat_e5.b_delta", {27'd0, dlb},        32'd1);
        step("lat_e6");
        chk("lat_e6.b_adv",   {31'd0, advb},       32'd0);

        // Increment through the wrap 31 -> 0
        for (int i = 2; i <= 33; i++) begin
            wa[4:0] = b2g(5'(i));
            wb      = b2g(5'(i));
            step("wrap");
        end
        repeat (5) step("wrap_settle");
        chk("wrap.a_err", {31'd0, erra[0]}, 32'd0);
        chk("wrap.b_err", {31'd0, errb},    32'd0);

        // Full-depth step is legal; one more is not
        rrst = 1'b1;
        wa = '0;
        wb = '0;
        step("big_rst");
        rrst = 1'b0;
        repeat (2) step("big_idle");
        wa[4:0] = 5'b11000;
        wb      = 5'b11000;
        repeat (3) step("big16");
        chk("big16.a_delta", {27'd0, dla[4:0]}, 32'd16);
        chk("big16.a_err",   {31'd0, erra[0]},  32'd0);
        repeat (2) step("big16_b");
        chk("big16.b_delta", {27'd0, dlb}, 32'd16);
        wa[4:0] = 5'b00001;
        wb      = 5'b00001;
        repeat (3) step("big17");
        chk("big17.a_delta", {27'd0, dla[4:0]}, 32'd17);
        chk("big17.a_err",   {31'd0, erra[0]},  32'd1);
        repeat (2) step("big17_b");
        chk("big17.b_err", {31'd0, errb}, 32'd1);
        clra = 3'b001;
        clrb = 1'b1;
        step("big_clr");
        chk("big_clr.a_err", {31'd0, erra[0]}, 32'd0);
        clra = '0;
        clrb = 1'b0;
        wa[4:0] = b2g(5'd19);
        wb      = b2g(5'd19);
        repeat (2) step("coin_pre");
        clra = 3'b001;
        step("coin");
        chk("coin.a_err", {31'd0, erra[0]}, 32'd1);
        clra = '0;
        repeat (3) step("coin_post");

        // Only channel 1 moves
        rrst = 1'b1;
        wa = '0;
        wb = '0;
        step("ch_rst");
        rrst = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            wa = {5'd0, b2g(5'(i)), 5'd0};
            step("ch");
        end
        repeat (4) step("ch_settle");
        chk("ch.c1_bin", {27'd0, rqa_b[9:5]}, 32'd8);
        chk("ch.c0_bin", {27'd0, rqa_b[4:0]}, 32'd0);
        chk("ch.c2_bin", {27'd0, rqa_b[14:10]}, 32'd0);
        chk("ch.adv02",  {30'd0, adva[2], adva[0]}, 32'd0);

        // Asynchronous reset mid-stream, then resume from 0
        for (int i = 1; i <= 12; i++) begin
            wa = {3{b2g(5'(i))}};
            wb = b2g(5'(i));
            step("mid_inc");
        end
        async_rst("mid_arst");
        wa = '0;
        wb = '0;
        step("mid_held");
        rrst = 1'b0;
        repeat (3) step("mid_idle");
        for (int i = 1; i <= 6; i++) begin
            wa = {3{b2g(5'(i))}};
            wb = b2g(5'(i));
            step("mid_resume");
        end
        repeat (5) step("mid_settle");
        chk("mid.a_err", {29'd0, erra}, 32'd0);
        chk("mid.b_err", {31'd0, errb}, 32'd0);

        // Randomised multi-count steps, clears and occasional resets
        for (int c = 0; c < 3; c++) pa[c] = 5'd6;
        pb = 5'd6;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < 3; c++) begin
                pa[c] = pa[c] + 5'($urandom_range(0, 20));
                wa[c*5 +: 5] = b2g(pa[c]);
                clra[c] = ($urandom_range(0, 3) == 0);
            end
            pb   = pb + 5'($urandom_range(0, 20));
            wb   = b2g(pb);
            clrb = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                async_rst("rnd_arst");
                step("rnd_held");
                rrst = 1'b0;
            end
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_ptr_w2r_mc.md
# sync_ptr_w2r_mc

Parametrised, multi-channel successor to the two-flop write-pointer synchroniser. Each channel carries a Gray-coded FIFO write pointer into the read clock domain through a configurable number of synchroniser stages. A registered decode stage then adds:

- Gray-to-binary conversion,
- per-sample advance pulse and step count,
- a sticky pointer-integrity error.

It sits on the read side of the async FIFOs, feeding empty/level logic.

## Interface

Parameters:

- ADDR_WIDTH, 4: FIFO address width. Pointer width PW = ADDR_WIDTH+1.
- SYNC_STAGES, 2: synchroniser depth. Legal range 2..4; elaborate-time error outside this range.
- NUM_CH, 1: number of independent pointer channels (1..8).

Ports:

- rclk, input, 1: read-domain clock; all flops on rising edge.
- rrst, input, 1: reset, asynchronous, active-high. All flops clear immediately on assertion. Deassertion is synchronised to rclk upstream.
- wptr_gray, input, NUM_CH*PW: Gray write pointers from the write domain. Channel c occupies bits [c*PW +: PW].
- err_clr, input, NUM_CH: per-channel synchronous clear of the sticky error.
- rq_wptr_gray, output, NUM_CH*PW: synchronised Gray pointer, taken from the last synchroniser stage.
- rq_wptr_bin, output, NUM_CH*PW: registered binary decode of rq_wptr_gray.
- wptr_adv, output, NUM_CH: one-cycle pulse when the decoded pointer changed.
- wptr_delta, output, NUM_CH*PW: registered step size (current bin minus previous bin, mod 2^PW).
- ptr_err, output, NUM_CH: sticky flag; the pointer stepped by more than FIFO depth.

## Operation

Per channel, all channels fully independent:

- **Synchroniser chain.** s[0] <= wptr_gray slice; s[k] <= s[k-1] for k = 1..SYNC_STAGES-1. rq_wptr_gray = s[SYNC_STAGES-1]. No logic between stages.
- **Decode stage**, one register set per channel:
  - bin <= gray2bin(rq_wptr_gray), where b[PW-1] = g[PW-1] and b[i] = b[i+1] ^ g[i].
  - prev_bin holds the previous value of bin, updated every cycle.
  - wptr_delta <= gray2bin(rq_wptr_gray) - bin, PW-bit modular subtraction. Wrap from 2^PW-1 to 0 gives delta 1.
  - wptr_adv <= (gray2bin(rq_wptr_gray) != bin).
- **Integrity check.** A step is illegal when the computed delta is greater than 2^ADDR_WIDTH. Delta equal to 2^ADDR_WIDTH (a full FIFO's worth) is legal.
  - An illegal step sets ptr_err on the same edge that registers the delta.
  - ptr_err stays set until err_clr=1 on a rising edge.
  - If err_clr and a new illegal step coincide, set wins.
- **No input qualification.** Delta is computed every cycle, and zero delta is normal idle.

## Timing

- Reset values: every synchroniser stage, rq_wptr_gray, rq_wptr_bin, wptr_delta, wptr_adv and ptr_err are all 0.
- Latency, with input stable before edge 1:
  - rq_wptr_gray updates after SYNC_STAGES edges.
  - rq_wptr_bin, wptr_delta, wptr_adv and ptr_err update one edge later, i.e. after SYNC_STAGES+1 edges.
- wptr_adv is high for exactly one cycle per decoded change. Back-to-back changes give consecutive pulses, each with its own delta.
- **Reset mid-operation.** All state clears asynchronously.
  - After release, the first samples are compared against 0, so a nonzero pointer produces wptr_adv plus its delta.
  - An illegal step here sets ptr_err. This is intended: the write side must reset together.
- Multi-bit Gray transitions are legal; fast wclk can advance the pointer several counts per rclk. Only the magnitude check applies.
- Throughput: a new pointer value can be accepted every cycle.

## Test plan

- **Reset.** Hold rrst=1 with wptr_gray=5'b10101 → all outputs 0. Release → after 3 edges, rq_wptr_bin=25, wptr_delta=25, and ptr_err=1 because 25 > 16.
- **Latency.** SYNC_STAGES=2, ADDR_WIDTH=4, wptr_gray 0→5'b00001 held:
  - rq_wptr_gray=1 after edge 2.
  - After edge 3: rq_wptr_bin=1, wptr_delta=1, wptr_adv=1.
  - After edge 4: wptr_adv=0, wptr_delta=0.
  - Repeat with SYNC_STAGES=4; the same updates occur at edges 4 and 5.
- **Wrap.** Step the pointer through Gray codes of 30, 31, 0 → rq_wptr_bin reads 30, 31, 0; wptr_delta=1 each step; ptr_err=0.
- **Multi-count step and error.**
  - Gray(0)→Gray(16)=5'b11000 → delta=16, ptr_err stays 0.
  - Then Gray(16)→Gray(1)=5'b00001 → delta=17, ptr_err=1.
  - err_clr alone → ptr_err=0 on the next edge.
  - err_clr in the same cycle as another illegal step → ptr_err stays 1.
- **Channels.** NUM_CH=3; drive only channel 1 through 0..40 incrementing → channel 1 matches the binary count with delta=1 per step; channels 0 and 2 stay all-zero with wptr_adv=0.
- **Reset mid-stream.** Assert rrst between edges during incrementing → outputs go 0 without waiting for rclk. Resume from pointer 0 → no error, normal latency.
